// File: rtl/cifra_xor_arbiter.sv
// Round-robin arbiter that shares one cifra_xor core among N_REQ requesters.
// Jobs are latched, run on the core under a watchdog, and answered with a one-cycle pulse.
module cifra_xor_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_plaintext,
  input  logic [N_REQ*DATA_W-1:0]   req_key,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_ciphertext,
  output logic                      rsp_error,
  output logic                      core_start,
  output logic [DATA_W-1:0]         core_plaintext,
  output logic [DATA_W-1:0]         core_key,
  input  logic [DATA_W-1:0]         core_ciphertext,
  input  logic                      core_done,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, RESP, DRAIN} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [PTR_W-1:0]  r_rrPtr;
  logic [PTR_W-1:0]  r_grantId;
  logic [PTR_W-1:0]  w_pick;
  logic              w_found;
  logic [WD_W-1:0]   r_watchdog;
  logic              w_wdLast;
  logic [DATA_W-1:0] r_corePt;
  logic [DATA_W-1:0] r_coreKey;
  logic [DATA_W-1:0] r_rspCt;
  logic              r_rspErr;
  logic [DATA_W-1:0] w_reqPt  [N_REQ];
  logic [DATA_W-1:0] w_reqKey [N_REQ];

  // Modulo-N_REQ add, correct for non-power-of-two N_REQ.
  function automatic logic [PTR_W-1:0] wrapAdd(input logic [PTR_W-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : gUnpack
    assign w_reqPt[g]  = req_plaintext[g*DATA_W +: DATA_W];
    assign w_reqKey[g] = req_key[g*DATA_W +: DATA_W];
  end

  assign w_wdLast = (r_watchdog == WD_W'(TIMEOUT - 1));

  // First requesting index at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rrPtr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req_valid[wrapAdd(r_rrPtr, i)]) begin
        w_found = 1'b1;
        w_pick  = wrapAdd(r_rrPtr, i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_found) w_nextState = LOAD;
      LOAD:    w_nextState = RUN;
      RUN:     if (core_done || w_wdLast) w_nextState = RESP;
      RESP:    w_nextState = DRAIN;
      DRAIN:   if (!core_done || w_wdLast) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (r_state == LOAD) && (r_grantId == PTR_W'(i));
      rsp_valid[i] = (r_state == RESP) && (r_grantId == PTR_W'(i));
    end
    core_start = (r_state == RUN);
    busy       = (r_state != IDLE);
  end

  // The watchdog is reused: it times RUN, restarts at zero, then bounds DRAIN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rrPtr    <= '0;
      r_grantId  <= '0;
      r_watchdog <= '0;
      r_corePt   <= '0;
      r_coreKey  <= '0;
      r_rspCt    <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_watchdog <= '0;
          if (w_found) r_grantId <= w_pick;
        end
        LOAD: begin
          r_corePt  <= w_reqPt[r_grantId];
          r_coreKey <= w_reqKey[r_grantId];
          r_rrPtr   <= wrapAdd(r_grantId, 1);
        end
        RUN: begin
          if (core_done) begin
            r_rspCt    <= core_ciphertext;
            r_rspErr   <= 1'b0;
            r_watchdog <= '0;
          end else if (w_wdLast) begin
            r_rspCt    <= '0;
            r_rspErr   <= 1'b1;
            r_watchdog <= '0;
          end else begin
            r_watchdog <= r_watchdog + 1'b1;
          end
        end
        DRAIN: begin
          if (!core_done || w_wdLast) r_watchdog <= '0;
          else                        r_watchdog <= r_watchdog + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign grant_id       = r_grantId;
  assign core_plaintext = r_corePt;
  assign core_key       = r_coreKey;
  assign rsp_ciphertext = r_rspCt;
  assign rsp_error      = r_rspErr;

endmodule

// File: tb/tb_cifra_xor_arbiter.sv
// Scoreboard bench for cifra_xor_arbiter with a behavioural XOR core of programmable latency.
module tb_cifra_xor_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_plaintext;
  logic [N*W-1:0] req_key;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_ciphertext;
  logic           rsp_error;
  logic           core_start;
  logic [W-1:0]   core_plaintext;
  logic [W-1:0]   core_key;
  logic [W-1:0]   core_ciphertext;
  logic           core_done;
  logic           busy;
  logic [1:0]     grant_id;

  typedef struct {
    int         idx;
    logic [7:0] ct;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         startCnt = 0;
  int         coreLatency = 10;
  bit         coreStuck = 1'b0;
  int         coreCnt;
  logic [N-1:0] lastReady = '0;
  logic       lastBusy = 1'b0;

  cifra_xor_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_plaintext(req_plaintext), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ciphertext(rsp_ciphertext), .rsp_error(rsp_error),
    .core_start(core_start), .core_plaintext(core_plaintext), .core_key(core_key),
    .core_ciphertext(core_ciphertext), .core_done(core_done),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Core raises done coreLatency cycles into a start and holds it until start drops.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      coreCnt <= 0;
      core_done <= 1'b0;
      core_ciphertext <= '0;
    end else if (!core_start) begin
      coreCnt <= 0;
      core_done <= 1'b0;
    end else begin
      coreCnt <= coreCnt + 1;
      if (!coreStuck && coreCnt == coreLatency - 1) begin
        core_done <= 1'b1;
        core_ciphertext <= core_plaintext ^ core_key;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected rsp_valid", 32'(rsp_valid), 32'd0);
    end else begin
      e = sb.pop_front();
      check("rsp_valid owner", 32'(rsp_valid), 32'd1 << e.idx);
      check("rsp_ciphertext", 32'(rsp_ciphertext), 32'(e.ct));
      check("rsp_error", 32'(rsp_error), 32'(e.err));
    end
  endtask

  always @(negedge clk) begin
    if (core_start) startCnt++;
    if (rsp_valid != '0) checkOutput();
  end

  task automatic raiseReq(input int idx, input logic [7:0] pt, input logic [7:0] key);
    req_plaintext[idx*W +: W] = pt;
    req_key[idx*W +: W] = key;
    req_valid[idx] = 1'b1;
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] pt, input logic [7:0] key,
                               input logic [7:0] expCt, input logic expErr);
    exp_t e;
    e.idx = idx;
    e.ct  = expCt;
    e.err = expErr;
    raiseReq(idx, pt, key);
    sb.push_back(e);
  endtask

  // One cycle: sample at negedge, then drop any request whose handshake just completed.
  task automatic tick();
    @(negedge clk);
    lastReady = req_ready;
    lastBusy = busy;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~lastReady;
  endtask

  task automatic waitReady(input int idx);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!lastReady[idx] && n < 100);
    check("ready handshake", 32'(lastReady[idx]), 32'd1);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(sb.size() == 0 && !lastBusy) && n < 300);
    check(name, 32'(sb.size() == 0 && !lastBusy), 32'd1);
  endtask

  logic [7:0] rrKeys [4] = '{8'hB7, 8'hFF, 8'h00, 8'h0F};
  logic [7:0] rrExp  [4] = '{8'h48, 8'h00, 8'hFF, 8'hF0};

  initial begin
    reset = 1'b0;
    req_valid = '0;
    req_plaintext = '0;
    req_key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset core_start", 32'(core_start), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset grant_id", 32'(grant_id), 32'd0);
    check("reset core_plaintext", 32'(core_plaintext), 32'd0);
    check("reset core_key", 32'(core_key), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    $display("[TB] single job");
    applyStimulus(0, 8'h48, 8'hB7, 8'hFF, 1'b0);
    tick();
    check("ready before grant", 32'(lastReady), 32'd0);
    tick();
    check("ready one cycle later", 32'(lastReady), 32'b0001);
    waitDrain("single job drained");
    check("rsp_ciphertext holds", 32'(rsp_ciphertext), 32'hFF);

    $display("[TB] reset during RUN");
    coreStuck = 1'b1;
    raiseReq(2, 8'h01, 8'h02);
    waitReady(2);
    repeat (3) tick();
    check("core_start in RUN", 32'(core_start), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid reset core_start", 32'(core_start), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset req_ready", 32'(req_ready), 32'd0);
    check("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    coreStuck = 1'b0;

    $display("[TB] round robin");
    for (int i = 0; i < 4; i++) applyStimulus(i, 8'hFF, rrKeys[i], rrExp[i], 1'b0);
    waitDrain("round robin drained");
    applyStimulus(0, 8'h11, 8'h22, 8'h33, 1'b0);
    applyStimulus(2, 8'h80, 8'h01, 8'h81, 1'b0);
    waitDrain("wrap drained");

    $display("[TB] fairness");
    applyStimulus(1, 8'h0C, 8'h30, 8'h3C, 1'b0);
    waitReady(1);
    applyStimulus(3, 8'h55, 8'hAA, 8'hFF, 1'b0);
    applyStimulus(1, 8'h12, 8'h34, 8'h26, 1'b0);
    waitDrain("fairness drained");

    $display("[TB] timeout");
    coreStuck = 1'b1;
    startCnt = 0;
    applyStimulus(0, 8'h77, 8'h11, 8'h00, 1'b1);
    waitDrain("timeout drained");
    check("timeout start cycles", 32'(startCnt), 32'd32);
    coreStuck = 1'b0;
    coreLatency = 4;
    applyStimulus(2, 8'h3C, 8'h5A, 8'h66, 1'b0);
    waitDrain("after timeout drained");

    $display("[TB] done on last watchdog cycle");
    coreLatency = 31;
    startCnt = 0;
    applyStimulus(3, 8'hA5, 8'h0F, 8'hAA, 1'b0);
    waitDrain("collision drained");
    check("collision start cycles", 32'(startCnt), 32'd32);

    $display("[TB] done one cycle too late");
    coreLatency = 32;
    startCnt = 0;
    applyStimulus(1, 8'h10, 8'h01, 8'h00, 1'b1);
    waitDrain("late done drained");
    check("late done start cycles", 32'(startCnt), 32'd32);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
